// File: rtl/alu_reg_seq_if.sv
// Bus interface for alu_reg_seq: operand/function/request in, status/result out.
// Handshake: a request is accepted on a rising edge where Start=1 and Busy=0;
// Start while Busy=1 is dropped (no queueing); Done pulses for the single
// cycle after ALUout takes a new value and is never high together with Busy.
// dbg_run mirrors the multiplier FSM state (1 = RUN) for observation only.
interface alu_reg_seq_if #(
  parameter int W = 4
);
  logic [W-1:0]   Data;
  logic [2:0]     Function;
  logic           Start;
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] ALUout;
  logic           dbg_run;

  modport master (
    output Data, Function, Start,
    input  Busy, Done, ALUout, dbg_run
  );

  modport slave (
    input  Data, Function, Start,
    output Busy, Done, ALUout, dbg_run
  );
endinterface

// File: rtl/alu_reg_seq.sv
// alu_reg_seq: registered ALU with a 2W-bit accumulator. Operand A is Data,
// operand B is the low half of the result register, so results chain.
// Optional macro ALU_MUL_EN builds the multi-cycle shift-add multiplier for
// Function 110; without it, 110 is a single-cycle op that writes zero.
module alu_reg_seq #(
  parameter int W = 4
) (
  input logic         Clock,
  input logic         Reset_b,
  alu_reg_seq_if.slave bus
);

  localparam logic [2:0] FN_ADD  = 3'b000;
  localparam logic [2:0] FN_SUB  = 3'b001;
  localparam logic [2:0] FN_SEXT = 3'b010;
  localparam logic [2:0] FN_ROR  = 3'b011;
  localparam logic [2:0] FN_RAND = 3'b100;
  localparam logic [2:0] FN_CAT  = 3'b101;
  localparam logic [2:0] FN_MUL  = 3'b110;
  localparam logic [2:0] FN_HOLD = 3'b111;

  logic [2*W-1:0] alu_q, alu_d;
  logic           done_q, done_d;

  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           accept;
  logic           mul_go;
  logic           mul_last;
  logic [2*W-1:0] mul_result;
  logic           run_dbg;
  logic [2*W-1:0] sc_result;
  logic [W:0]     sum_w1;
  logic [W:0]     diff_w1;

  assign op_a   = bus.Data;
  assign op_b   = alu_q[W-1:0];
  assign accept = bus.Start && !busy;

  // W+1-bit add/sub so carry/borrow is never lost.
  assign sum_w1  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w1 = {1'b0, op_a} - {1'b0, op_b};

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mul_state_e;

  mul_state_e     state_q, state_d;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] prod_q;
  logic [CW-1:0]  cnt_q;

  assign mul_go = accept && (bus.Function == FN_MUL);

  // Multiplier state register.
  always_ff @(posedge Clock) begin
    if (!Reset_b) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Multiplier next state: RUN lasts exactly W edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul_go) state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier outputs: Busy in RUN, last step flagged when count reaches 1.
  always_comb begin
    busy     = 1'b0;
    mul_last = 1'b0;
    run_dbg  = 1'b0;
    case (state_q)
      S_RUN: begin
        busy     = 1'b1;
        mul_last = (cnt_q == CW'(1));
        run_dbg  = 1'b1;
      end
      default: ;
    endcase
  end

  // Partial product including this step's conditional add.
  assign mul_result = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  // Shift-add datapath: operands latched at accept so Data/Function may move.
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (mul_go) begin
      mcand_q  <= {{W{1'b0}}, op_a};
      mplier_q <= op_b;
      prod_q   <= '0;
      cnt_q    <= CW'(W);
    end else if (state_q == S_RUN) begin
      prod_q   <= mul_result;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end
`else
  assign busy       = 1'b0;
  assign mul_go     = 1'b0;
  assign mul_last   = 1'b0;
  assign mul_result = '0;
  assign run_dbg    = 1'b0;
`endif

  // Single-cycle result; FN_MUL here only matters when no multiplier is built.
  always_comb begin
    sc_result = alu_q;
    case (bus.Function)
      FN_ADD:  sc_result = {{(W-1){1'b0}}, sum_w1};
      FN_SUB:  sc_result = {{(W-1){diff_w1[W]}}, diff_w1};
      FN_SEXT: sc_result = {{W{op_a[W-1]}}, op_a};
      FN_ROR:  sc_result = {{(2*W-1){1'b0}}, |{op_a, op_b}};
      FN_RAND: sc_result = {{(2*W-1){1'b0}}, &{op_a, op_b}};
      FN_CAT:  sc_result = {op_a, op_b};
      FN_MUL:  sc_result = '0;
      FN_HOLD: sc_result = alu_q;
      default: sc_result = alu_q;
    endcase
  end

  // Result/Done next state: single-cycle ops at accept, product at last step.
  always_comb begin
    alu_d  = alu_q;
    done_d = 1'b0;
    if (accept && !mul_go) begin
      alu_d  = sc_result;
      done_d = 1'b1;
    end
    if (mul_last) begin
      alu_d  = mul_result;
      done_d = 1'b1;
    end
  end

  // Result and Done registers; reset overrides any in-flight multiply.
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      alu_q  <= '0;
      done_q <= 1'b0;
    end else begin
      alu_q  <= alu_d;
      done_q <= done_d;
    end
  end

  assign bus.ALUout  = alu_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = busy;
  assign bus.dbg_run = run_dbg;

endmodule

// File: tb/tb_alu_reg_seq.sv
// Directed bench for alu_reg_seq (W=4). Multiply checks are built when
// ALU_MUL_EN is defined; otherwise Function 110 is checked as write-zero.
module tb_alu_reg_seq;
  localparam int W = 4;

  logic Clock;
  logic Reset_b;
  int   n_cmp;
  int   n_err;

  alu_reg_seq_if #(.W(W)) bus_if ();

  alu_reg_seq #(.W(W)) dut (
    .Clock  (Clock),
    .Reset_b(Reset_b),
    .bus    (bus_if)
  );

  // Clock and counters
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One single-cycle request; checks result, Done pulse width and Busy.
  task automatic issue(input logic [2:0] fn, input logic [W-1:0] a,
                       input logic [2*W-1:0] exp, input string tag);
    bus_if.Function = fn;
    bus_if.Data     = a;
    bus_if.Start    = 1'b1;
    tick();
    bus_if.Start    = 1'b0;
    check({tag, "_alu"},  16'(bus_if.ALUout), 16'(exp));
    check({tag, "_done"}, 16'(bus_if.Done), 16'd1);
    check({tag, "_busy"}, 16'(bus_if.Busy), 16'd0);
    tick();
    check({tag, "_done_off"}, 16'(bus_if.Done), 16'd0);
  endtask

`ifdef ALU_MUL_EN
  // Multiply with an ignored Start mid-run; Data/Function wiggle while Busy.
  task automatic mul_run(input logic [W-1:0] a, input logic [2*W-1:0] hold,
                         input logic [2*W-1:0] exp, input string tag);
    bus_if.Function = 3'b110;
    bus_if.Data     = a;
    bus_if.Start    = 1'b1;
    tick();
    for (int i = 0; i < W; i++) begin
      bus_if.Start = 1'b0;
      check({tag, "_busy_run"}, 16'(bus_if.Busy), 16'd1);
      check({tag, "_alu_hold"}, 16'(bus_if.ALUout), 16'(hold));
      check({tag, "_done_run"}, 16'(bus_if.Done), 16'd0);
      if (i == 1) begin
        bus_if.Function = 3'b000;
        bus_if.Data     = 4'h1;
        bus_if.Start    = 1'b1;
      end
      tick();
    end
    bus_if.Start = 1'b0;
    check({tag, "_alu"},  16'(bus_if.ALUout), 16'(exp));
    check({tag, "_done"}, 16'(bus_if.Done), 16'd1);
    check({tag, "_busy"}, 16'(bus_if.Busy), 16'd0);
  endtask
`endif

  // Directed sequence
  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset_b         = 1'b0;
    bus_if.Start    = 1'b0;
    bus_if.Data     = '0;
    bus_if.Function = 3'b000;
    repeat (2) tick();
    Reset_b = 1'b1;
    check("rst_alu",  16'(bus_if.ALUout), 16'h00);
    check("rst_busy", 16'(bus_if.Busy), 16'd0);
    check("rst_done", 16'(bus_if.Done), 16'd0);

    // Activity, then reset with a Start present
    issue(3'b101, 4'hA, 8'hA0, "cat_pre");
    Reset_b         = 1'b0;
    bus_if.Function = 3'b101;
    bus_if.Data     = 4'h5;
    bus_if.Start    = 1'b1;
    tick();
    bus_if.Start = 1'b0;
    Reset_b      = 1'b1;
    check("rst2_alu",  16'(bus_if.ALUout), 16'h00);
    check("rst2_busy", 16'(bus_if.Busy), 16'd0);
    check("rst2_done", 16'(bus_if.Done), 16'd0);

    // Add / sub / sign-extend / reductions / concat / hold
    issue(3'b000, 4'h3, 8'h03, "add0");
    issue(3'b000, 4'h5, 8'h08, "add1");
    issue(3'b000, 4'hF, 8'h17, "add_carry");
    issue(3'b010, 4'h5, 8'h05, "sext_pos");
    issue(3'b001, 4'h2, 8'hFD, "sub_neg");
    issue(3'b010, 4'h9, 8'hF9, "sext_neg");
    issue(3'b011, 4'h0, 8'h01, "ror_one");
    issue(3'b100, 4'hF, 8'h00, "rand_zero");
    issue(3'b010, 4'hF, 8'hFF, "sext_ff");
    issue(3'b100, 4'hF, 8'h01, "rand_one");
    issue(3'b111, 4'h3, 8'h01, "hold");
    issue(3'b101, 4'hC, 8'hC1, "cat");
    issue(3'b010, 4'h0, 8'h00, "clear");
    issue(3'b011, 4'h0, 8'h00, "ror_zero");
    issue(3'b010, 4'h3, 8'h03, "set3");
    issue(3'b001, 4'hF, 8'h0C, "sub_pos");

    // Back-to-back: one result per cycle (B=0xC here)
    bus_if.Function = 3'b000;
    bus_if.Data     = 4'h2;
    bus_if.Start    = 1'b1;
    tick();
    check("b2b0_alu",  16'(bus_if.ALUout), 16'h0E);
    check("b2b0_done", 16'(bus_if.Done), 16'd1);
    bus_if.Data = 4'h4;
    tick();
    bus_if.Start = 1'b0;
    check("b2b1_alu",  16'(bus_if.ALUout), 16'h12);
    check("b2b1_done", 16'(bus_if.Done), 16'd1);
    tick();
    check("b2b_done_off", 16'(bus_if.Done), 16'd0);

`ifdef ALU_MUL_EN
    issue(3'b010, 4'h6, 8'h06, "set6");
    mul_run(4'h7, 8'h06, 8'h2A, "mul76");
    tick();
    check("mul76_done_off", 16'(bus_if.Done), 16'd0);
    check("mul76_alu_keep", 16'(bus_if.ALUout), 16'h2A);
    issue(3'b010, 4'hF, 8'hFF, "setff");
    mul_run(4'hF, 8'hFF, 8'hE1, "mulff");
    // Accepted on the edge where Done is high
    issue(3'b000, 4'h1, 8'h02, "after_mul");

    // Reset on the 2nd cycle of a multiply
    issue(3'b010, 4'h3, 8'h03, "set3m");
    bus_if.Function = 3'b110;
    bus_if.Data     = 4'h5;
    bus_if.Start    = 1'b1;
    tick();
    bus_if.Start = 1'b0;
    check("mrst_busy1", 16'(bus_if.Busy), 16'd1);
    tick();
    Reset_b = 1'b0;
    tick();
    Reset_b = 1'b1;
    check("mrst_alu",  16'(bus_if.ALUout), 16'h00);
    check("mrst_busy", 16'(bus_if.Busy), 16'd0);
    check("mrst_done", 16'(bus_if.Done), 16'd0);
    for (int i = 0; i < W + 1; i++) begin
      tick();
      check("mrst_no_done", 16'(bus_if.Done), 16'd0);
      check("mrst_no_busy", 16'(bus_if.Busy), 16'd0);
    end
    issue(3'b000, 4'h9, 8'h09, "mrst_after");
`else
    issue(3'b010, 4'h6, 8'h06, "set6");
    issue(3'b110, 4'h7, 8'h00, "mul_off");
    issue(3'b000, 4'h1, 8'h01, "after_mul_off");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_reg_seq.md
Name: alu_reg_seq

Overview:
- Parametrised registered ALU with an accumulator.
- Operand A comes from the Data input; operand B is the low half of the block's own result register, so results chain across operations.
- Most operations finish in one cycle. Multiply is a multi-cycle shift-add sequence with a Start/Busy/Done handshake.
- The block sits between switch/key inputs and HEX/LED display logic on the lab board top level.

Parameters:
W, 4, operand width in bits (W >= 2). The result register is 2W bits.

Ports:
Clock  input  1  system clock; all state changes on rising edge
Reset_b  input  1  synchronous active-low reset, sampled on rising edge of Clock
Data  input  W  operand A
Function  input  3  operation select, sampled with Start
Start  input  1  request; accepted on an edge where Start=1 and Busy=0
Busy  output  1  high while a multiply is in progress
Done  output  1  one-cycle pulse when ALUout takes a new result
ALUout  output  2W  result register; B = ALUout[W-1:0]

Behaviour:
- Reset: Reset_b=0 at an edge clears the following, overriding everything including an in-flight multiply:
  - ALUout=0, Busy=0, Done=0
  - multiplier state returns to IDLE
- Function map (A=Data, B=ALUout[W-1:0], all captured at the accept edge):
  - 000: A+B, unsigned; carry-out in bit W, upper bits zero.
  - 001: A-B, two's complement, W+1-bit difference sign-extended to 2W.
  - 010: A sign-extended to 2W.
  - 011: reduce-OR of {A,B} in bit 0, other bits zero.
  - 100: reduce-AND of {A,B} in bit 0, other bits zero.
  - 101: {A,B}, A in the upper half.
  - 110: A*B, unsigned, 2W-bit product, multi-cycle.
  - 111: hold; ALUout unchanged, Done still pulses.
- Single-cycle ops:
  - ALUout is updated at the accept edge.
  - Done=1 for exactly the following cycle.
  - Busy stays 0.
  - Back-to-back Starts give one result per cycle.
- Multiply FSM, states IDLE -> RUN -> IDLE:
  - Accept edge: latch A, latch B, clear the partial product, load count=W, enter RUN, Busy=1. ALUout is unchanged during RUN.
  - Each RUN edge: if multiplier LSB=1, add the multiplicand (shifted) into the partial product; shift; decrement count.
  - At the W-th RUN edge the product loads into ALUout, the FSM returns to IDLE, Busy=0, and Done=1 for one cycle.
  - Total latency is W cycles from accept to result. Busy is high for exactly W cycles.
  - Start during Busy is ignored, not queued.
  - A new Start is accepted on the edge where Done is high (Busy=0 then).
- Function and Data may change freely while Busy; the latched operands are used.
- Done is never high in the same cycle as Busy.
- Wrap-around: add/sub results never truncate. A multiply of all-ones operands gives (2^W-1)^2 exactly.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: Function 110 is the multi-cycle multiply above.
- Undefined: no multiplier FSM or datapath is built, Busy is tied 0, and Function 110 behaves as a single-cycle op writing ALUout=0 with a Done pulse.

Test Plan (W=4):
- Reset_b=0 one edge after arbitrary activity -> ALUout=0x00, Busy=0, Done=0. Start during reset is ignored.
- ALUout=0x03, Data=5, Function=000, Start -> next cycle ALUout=0x08, Done=1 one cycle. Then Data=0xF, 000 -> ALUout=0x17 (carry in bit 4).
- ALUout=0x05, Data=2, Function=001 -> ALUout=0xFD. Then Data=0x9, 010 -> ALUout=0xF9. Then 011 with Data=0 and B=9 -> 0x01.
- ALUout=0x06, Data=7, Function=110, Start -> Busy high 4 cycles, ALUout holds 0x06 during them, then ALUout=0x2A and Done pulses. A Start with 000 issued mid-multiply is ignored. Data=0xF with B=0xF -> 0xE1.
- Reset_b=0 on the 2nd cycle of a multiply -> ALUout=0x00, Busy=0, no Done. A Start after reset is accepted normally.
- Build without ALU_MUL_EN: Function=110 -> ALUout=0x00 next cycle, Done=1, Busy never asserts.
